// File: rtl/break_resume_ctrl_if.sv
// Host command channel of the break/resume controller: valid/ready handshake carrying an opcode and a step count.
interface break_resume_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/break_resume_ctrl.sv
// Task-clock break/resume controller: stops the BUFGCE on break-source rising edges and releases it
// on host RESUME/STEP commands, latching the halt cause and counting executed task cycles.
module break_resume_ctrl #(
  parameter int CNT_W     = 32,
  parameter int CYC_W     = 64,
  parameter bit START_RUN = 1'b0
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic [2:0]       halt_src,
  break_resume_ctrl_if.slave cmd,
  output logic             clk_ce,
  output logic             halted,
  output logic [4:0]       halt_cause,
  output logic [CNT_W-1:0] step_remaining,
  output logic [CYC_W-1:0] cycles_run,
  output logic             cmd_err,
  output logic             evt_halt
);

  localparam logic [1:0] ST_HALTED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;

  localparam logic [1:0] OP_RESUME = 2'd0;
  localparam logic [1:0] OP_STEP   = 2'd1;
  localparam logic [1:0] OP_HALT   = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  localparam logic [1:0]       RESET_STATE = (START_RUN != 1'b0) ? ST_RUN : ST_HALTED;
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] CYC_ONE     = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [2:0]       halt_src_q_r;
  logic             halted_r;
  logic [4:0]       halt_cause_r;
  logic [CNT_W-1:0] step_rem_r;
  logic [CYC_W-1:0] cycles_run_r;
  logic             cmd_err_r;
  logic             evt_halt_r;

  logic             halt_rise_s;
  logic             active_s;
  logic             clk_ce_s;
  logic [1:0]       state_nxt_s;
  logic [4:0]       cause_nxt_s;
  logic [CNT_W-1:0] rem_nxt_s;
  logic             err_nxt_s;
  logic             evt_nxt_s;
  logic             clear_s;

  // A source held high across a RESUME must drop before it can break again, hence edge detection.
  assign halt_rise_s = |(halt_src & ~halt_src_q_r);
  assign active_s    = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign clk_ce_s    = active_s & ~halt_rise_s;

  assign clk_ce         = clk_ce_s;
  assign halted         = halted_r;
  assign halt_cause     = halt_cause_r;
  assign step_remaining = step_rem_r;
  assign cycles_run     = cycles_run_r;
  assign cmd_err        = cmd_err_r;
  assign evt_halt       = evt_halt_r;
  assign cmd.cmd_ready  = 1'b1;

  // Next-state decode: a break edge pre-empts any command issued in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = halt_cause_r;
    rem_nxt_s   = step_rem_r;
    err_nxt_s   = 1'b0;
    evt_nxt_s   = 1'b0;
    clear_s     = 1'b0;
    if (halt_rise_s) begin
      err_nxt_s = cmd.cmd_valid;
      if (active_s) begin
        state_nxt_s = ST_HALTED;
        cause_nxt_s = {2'b00, halt_src};
        evt_nxt_s   = 1'b1;
      end else begin
        cause_nxt_s = {halt_cause_r[4:3], halt_cause_r[2:0] | halt_src};
      end
    end else begin
      case (state_r)
        ST_HALTED: begin
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              OP_RESUME: state_nxt_s = ST_RUN;
              OP_STEP: begin
                if (cmd.cmd_count != CNT_ZERO) begin
                  state_nxt_s = ST_STEP;
                  rem_nxt_s   = cmd.cmd_count;
                end else begin
                  cause_nxt_s = halt_cause_r | 5'b01000;
                  evt_nxt_s   = 1'b1;
                end
              end
              OP_CLEAR: begin
                clear_s     = 1'b1;
                cause_nxt_s = 5'b00000;
              end
              default: state_nxt_s = state_r;
            endcase
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_RUN: begin
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              OP_HALT: begin
                state_nxt_s = ST_HALTED;
                cause_nxt_s = 5'b10000;
                evt_nxt_s   = 1'b1;
              end
              OP_CLEAR: begin
                clear_s     = 1'b1;
                cause_nxt_s = 5'b00000;
              end
              default: err_nxt_s = 1'b1;
            endcase
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_STEP: begin
          // CE is high here, so this cycle consumes one step; completion outranks a host halt.
          rem_nxt_s = step_rem_r - CNT_ONE;
          if (cmd.cmd_valid) begin
            case (cmd.cmd_op)
              OP_HALT: begin
                state_nxt_s = ST_HALTED;
                cause_nxt_s = 5'b10000;
                evt_nxt_s   = 1'b1;
              end
              OP_CLEAR: begin
                clear_s     = 1'b1;
                cause_nxt_s = 5'b00000;
              end
              default: err_nxt_s = 1'b1;
            endcase
          end else begin
            err_nxt_s = 1'b0;
          end
          if (step_rem_r == CNT_ONE) begin
            state_nxt_s = ST_HALTED;
            cause_nxt_s = 5'b01000;
            evt_nxt_s   = 1'b1;
          end else begin
            rem_nxt_s = step_rem_r - CNT_ONE;
          end
        end
        default: state_nxt_s = RESET_STATE;
      endcase
    end
  end

  // State, status and cycle-counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_r      <= RESET_STATE;
      halt_src_q_r <= 3'b000;
      halted_r     <= (RESET_STATE == ST_HALTED);
      halt_cause_r <= 5'b00000;
      step_rem_r   <= CNT_ZERO;
      cycles_run_r <= {CYC_W{1'b0}};
      cmd_err_r    <= 1'b0;
      evt_halt_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      halt_src_q_r <= halt_src;
      halted_r     <= (state_nxt_s == ST_HALTED);
      halt_cause_r <= cause_nxt_s;
      step_rem_r   <= rem_nxt_s;
      cmd_err_r    <= err_nxt_s;
      evt_halt_r   <= evt_nxt_s;
      if (clear_s) begin
        cycles_run_r <= {CYC_W{1'b0}};
      end else if (clk_ce_s) begin
        cycles_run_r <= cycles_run_r + CYC_ONE;
      end else begin
        cycles_run_r <= cycles_run_r;
      end
    end
  end

endmodule

// File: tb/tb_break_resume_ctrl.sv
// Directed bench for break_resume_ctrl: hand-computed expectations checked with immediate assertions.
module tb_break_resume_ctrl;
  logic        sys_clk;
  logic        sys_reset;
  logic [2:0]  halt_src;
  logic        clk_ce;
  logic        halted;
  logic [4:0]  halt_cause;
  logic [31:0] step_remaining;
  logic [63:0] cycles_run;
  logic        cmd_err;
  logic        evt_halt;

  int pass_cnt;
  int fail_cnt;
  int total_cnt;

  break_resume_ctrl_if #(.CNT_W(32)) cmd_if ();

  break_resume_ctrl #(.CNT_W(32), .CYC_W(64), .START_RUN(1'b0)) dut (
    .sys_clk        (sys_clk),
    .sys_reset      (sys_reset),
    .halt_src       (halt_src),
    .cmd            (cmd_if),
    .clk_ce         (clk_ce),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .step_remaining (step_remaining),
    .cycles_run     (cycles_run),
    .cmd_err        (cmd_err),
    .evt_halt       (evt_halt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] count);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_count = count;
    tick();
    cmd_if.cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    sys_reset = 1'b1;
    halt_src  = 3'b000;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_count = 32'd0;
    tick();
    tick();
    sys_reset = 1'b0;
    #1;
    chk("rst_halted", {63'd0, halted}, 64'd1);
    chk("rst_clk_ce", {63'd0, clk_ce}, 64'd0);
    chk("rst_cycles", cycles_run, 64'd0);
    chk("rst_cause", {59'd0, halt_cause}, 64'd0);
    chk("rst_ready", {63'd0, cmd_if.cmd_ready}, 64'd1);

    // RESUME from reset
    send(2'd0, 32'd0);
    chk("resume_ce", {63'd0, clk_ce}, 64'd1);
    chk("resume_halted", {63'd0, halted}, 64'd0);
    repeat (3) tick();
    chk("run_cycles3", cycles_run, 64'd3);

    // break source 010 rises in RUN
    halt_src = 3'b010;
    #1;
    chk("rise_ce_same_cycle", {63'd0, clk_ce}, 64'd0);
    tick();
    chk("rise_halted", {63'd0, halted}, 64'd1);
    chk("rise_evt", {63'd0, evt_halt}, 64'd1);
    chk("rise_cause", {59'd0, halt_cause}, 64'h02);
    chk("rise_cycles", cycles_run, 64'd3);
    tick();
    chk("rise_evt_pulse", {63'd0, evt_halt}, 64'd0);

    // held source does not re-halt after RESUME
    send(2'd0, 32'd0);
    chk("held_ce", {63'd0, clk_ce}, 64'd1);
    tick();
    tick();
    chk("held_running", {63'd0, halted}, 64'd0);
    chk("held_cycles", cycles_run, 64'd5);
    halt_src = 3'b000;
    tick();
    halt_src = 3'b010;
    #1;
    chk("rerise_ce", {63'd0, clk_ce}, 64'd0);
    tick();
    chk("rerise_halted", {63'd0, halted}, 64'd1);
    chk("rerise_cycles", cycles_run, 64'd6);

    // STEP 5
    send(2'd1, 32'd5);
    chk("step5_ce", {63'd0, clk_ce}, 64'd1);
    chk("step5_rem", {32'd0, step_remaining}, 64'd5);
    repeat (4) tick();
    chk("step5_rem1", {32'd0, step_remaining}, 64'd1);
    chk("step5_still_run", {63'd0, halted}, 64'd0);
    tick();
    chk("step5_halted", {63'd0, halted}, 64'd1);
    chk("step5_rem0", {32'd0, step_remaining}, 64'd0);
    chk("step5_cause", {59'd0, halt_cause}, 64'h08);
    chk("step5_evt", {63'd0, evt_halt}, 64'd1);
    chk("step5_cycles", cycles_run, 64'd11);
    chk("step5_ce_off", {63'd0, clk_ce}, 64'd0);

    // CLEAR then STEP 0
    send(2'd3, 32'd0);
    chk("clear_cause", {59'd0, halt_cause}, 64'd0);
    chk("clear_cycles", cycles_run, 64'd0);
    send(2'd1, 32'd0);
    chk("step0_halted", {63'd0, halted}, 64'd1);
    chk("step0_evt", {63'd0, evt_halt}, 64'd1);
    chk("step0_cause", {59'd0, halt_cause}, 64'h08);
    chk("step0_ce", {63'd0, clk_ce}, 64'd0);
    tick();
    chk("step0_cycles", cycles_run, 64'd0);

    // STEP 10 interrupted by source 001 after 3 CE cycles
    halt_src = 3'b000;
    send(2'd1, 32'd10);
    repeat (3) tick();
    chk("step10_rem7", {32'd0, step_remaining}, 64'd7);
    halt_src = 3'b001;
    #1;
    chk("step10_ce_off", {63'd0, clk_ce}, 64'd0);
    tick();
    chk("step10_halted", {63'd0, halted}, 64'd1);
    chk("step10_residue", {32'd0, step_remaining}, 64'd7);
    chk("step10_cause", {59'd0, halt_cause}, 64'h01);
    chk("step10_cycles", cycles_run, 64'd3);

    // RESUME collides with a break edge
    halt_src = 3'b000;
    send(2'd0, 32'd0);
    tick();
    chk("coll_pre_cycles", cycles_run, 64'd4);
    halt_src = 3'b100;
    send(2'd0, 32'd0);
    chk("coll_halted", {63'd0, halted}, 64'd1);
    chk("coll_err", {63'd0, cmd_err}, 64'd1);
    chk("coll_cause", {59'd0, halt_cause}, 64'h04);
    tick();
    chk("coll_err_pulse", {63'd0, cmd_err}, 64'd0);
    send(2'd3, 32'd0);
    chk("clear2_cause", {59'd0, halt_cause}, 64'd0);
    chk("clear2_cycles", cycles_run, 64'd0);

    // host HALT in RUN, then illegal STEP in RUN
    halt_src = 3'b000;
    send(2'd0, 32'd0);
    tick();
    chk("host_ce", {63'd0, clk_ce}, 64'd1);
    send(2'd2, 32'd0);
    chk("host_halted", {63'd0, halted}, 64'd1);
    chk("host_cause", {59'd0, halt_cause}, 64'h10);
    chk("host_evt", {63'd0, evt_halt}, 64'd1);
    chk("host_cycles", cycles_run, 64'd2);
    send(2'd0, 32'd0);
    send(2'd1, 32'd4);
    chk("run_step_err", {63'd0, cmd_err}, 64'd1);
    chk("run_step_running", {63'd0, halted}, 64'd0);
    chk("run_step_cycles", cycles_run, 64'd3);

    // reset in the middle of a STEP
    send(2'd2, 32'd0);
    send(2'd1, 32'd10);
    tick();
    chk("mid_rem9", {32'd0, step_remaining}, 64'd9);
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    #1;
    chk("mid_rst_halted", {63'd0, halted}, 64'd1);
    chk("mid_rst_rem", {32'd0, step_remaining}, 64'd0);
    chk("mid_rst_cycles", cycles_run, 64'd0);
    chk("mid_rst_ce", {63'd0, clk_ce}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
